// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO multiply/divide controller for the
// execute stage. One operation at a time: fixed-latency multiply class
// (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) or a 32-step restoring divide
// (DIV/DIVU) followed by a sign-fix cycle. Ends with a one-cycle HI/LO write.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start, op      request (sampled in IDLE only) and operation
//   rs, rt         operands A (dividend/multiplicand), B (divisor/multiplier)
//   hi_in, lo_in   current HI/LO, accumulated by MADD*/MSUB*
//   flush          abort the operation in flight, no write-back
//   busy           operation in flight
//   done, hilo_we  one-cycle completion / HI-LO write strobe (identical)
//   hi_out, lo_out result, valid with done, held until the next done

package selector;
    typedef enum logic [3:0] {
        MULDIV_NCARE,
        MULDIV_MULT,
        MULDIV_MULTU,
        MULDIV_DIV,
        MULDIV_DIVU,
        MULDIV_MADD,
        MULDIV_MADDU,
        MULDIV_MSUB,
        MULDIV_MSUBU
    } muldiv_function;
endpackage

module muldiv_sequencer
    import selector::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  muldiv_function op,
    input  logic [31:0]    rs,
    input  logic [31:0]    rt,
    input  logic [31:0]    hi_in,
    input  logic [31:0]    lo_in,
    input  logic           flush,
    output logic           busy,
    output logic           done,
    output logic           hilo_we,
    output logic [31:0]    hi_out,
    output logic [31:0]    lo_out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t         r_state, w_next;
    logic           w_fin;
    logic [4:0]     r_cnt;
    muldiv_function r_op;
    logic [31:0]    r_a;          // original rs (needed for divide-by-zero HI)
    logic [31:0]    r_b;          // multiplier, or |divisor| for DIV
    logic [63:0]    r_acc;        // {hi_in, lo_in} snapshot
    logic [31:0]    r_quo;        // dividend shifts out MSB-first, quotient shifts in
    logic [31:0]    r_rem;
    logic           r_qneg, r_rneg;
    logic           r_busy, r_done;
    logic [31:0]    r_hi, r_lo;

    logic           w_is_mul, w_is_div, w_sdiv;
    logic           w_sgn;
    logic [63:0]    w_ea, w_eb, w_prod, w_res;
    logic [32:0]    w_rem_sh, w_rem_sub;
    logic           w_ge;

    assign w_is_mul = op inside {MULDIV_MULT, MULDIV_MULTU, MULDIV_MADD,
                                 MULDIV_MADDU, MULDIV_MSUB, MULDIV_MSUBU};
    assign w_is_div = op inside {MULDIV_DIV, MULDIV_DIVU};
    assign w_sdiv   = (op == MULDIV_DIV);

    // Next-state: flush overrides everything and suppresses the write-back.
    always_comb begin
        w_next = r_state;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_is_mul)      w_next = S_MUL;
                else if (start && w_is_div) w_next = S_DIV;
            end
            S_MUL: begin
                if (r_cnt == 5'd0) begin
                    w_next = S_IDLE;
                    w_fin  = 1'b1;
                end
            end
            S_DIV: begin
                if (r_cnt == 5'd0) w_next = S_FIX;
            end
            S_FIX: begin
                w_next = S_IDLE;
                w_fin  = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
            w_fin  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Multiply: sign/zero-extend to 64 bits; the low 64 bits of the 64x64
    // product are the correct signed or unsigned product mod 2^64.
    assign w_sgn  = r_op inside {MULDIV_MULT, MULDIV_MADD, MULDIV_MSUB};
    assign w_ea   = {{32{w_sgn & r_a[31]}}, r_a};
    assign w_eb   = {{32{w_sgn & r_b[31]}}, r_b};
    assign w_prod = w_ea * w_eb;

    // Restoring divide step.
    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh - {1'b0, r_b};

    always_comb begin
        w_res = 64'd0;
        if (r_state == S_FIX) begin
            // Zero divisor: raw restoring result with the original rs in HI.
            if (r_b == 32'd0) w_res = {r_a, 32'hFFFF_FFFF};
            else              w_res = {r_rneg ? 32'(-r_rem) : r_rem,
                                       r_qneg ? 32'(-r_quo) : r_quo};
        end else begin
            case (r_op)
                MULDIV_MADD, MULDIV_MADDU: w_res = r_acc + w_prod;
                MULDIV_MSUB, MULDIV_MSUBU: w_res = r_acc - w_prod;
                default:                   w_res = w_prod;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 5'd0;
            r_op   <= MULDIV_NCARE;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_acc  <= 64'd0;
            r_quo  <= 32'd0;
            r_rem  <= 32'd0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= w_fin;
            if (w_fin) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_next != S_IDLE) begin
                        r_op  <= op;
                        r_a   <= rs;
                        r_acc <= {hi_in, lo_in};
                        r_rem <= 32'd0;
                        if (w_is_mul) begin
                            r_b   <= rt;
                            r_cnt <= 5'(MUL_LATENCY - 1);
                        end else begin
                            r_b    <= (w_sdiv && rt[31]) ? 32'(-rt) : rt;
                            r_quo  <= (w_sdiv && rs[31]) ? 32'(-rs) : rs;
                            r_qneg <= w_sdiv && (rs[31] ^ rt[31]);
                            r_rneg <= w_sdiv && rs[31];
                            r_cnt  <= 5'd31;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign hilo_we = r_done;
    assign hi_out  = r_hi;
    assign lo_out  = r_lo;

endmodule
